iccm_boot_loader: RTL

- Sequences the initial program load into the ICCM before the Ibex core is allowed to fetch.
- Accepts a word stream over a valid/ready handshake: a length header, then payload words.
- Drives the ICCM direct-write port (we/wdata/wmask/waddr), one write per accepted word.
- Raises finish_o once the image is complete. finish_o replaces the testbench-driven finish strobe and gates core fetch enable.

---
 rtl/iccm_boot_loader_if.sv | 34 +++
 rtl/iccm_boot_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/iccm_boot_loader_if.sv
// Stream-in / ICCM-write bundle for iccm_boot_loader.
// slave = loader side, master = stream source and ICCM write sink.
interface iccm_boot_loader_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 32
);
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i;
    logic          iccm_we_o;
    logic [DW-1:0] iccm_wdata_o;
    logic [DW-1:0] iccm_wmask_o;
    logic [AW-1:0] iccm_waddr_o;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o,
        output iccm_we_o,
        output iccm_wdata_o,
        output iccm_wmask_o,
        output iccm_waddr_o
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o,
        input  iccm_we_o,
        input  iccm_wdata_o,
        input  iccm_wmask_o,
        input  iccm_waddr_o
    );
endinterface

// File: rtl/iccm_boot_loader.sv
// Loads a length-prefixed word stream into the ICCM and raises finish_o when done.
// Define ICCM_BOOT_CSUM_EN to require a trailing additive checksum word.
module iccm_boot_loader #(
    parameter int unsigned AW        = 11,
    parameter int unsigned DW        = 32,  // must equal top_pkg::TL_DW
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    iccm_boot_loader_if.slave bus,
    output logic              finish_o,
    output logic              err_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    // Largest image that still fits between BASE_ADDR and the top of the ICCM.
    localparam logic [AW:0] LEN_MAX = (AW+1)'(2**AW - BASE_ADDR);

    state_e      state_q;
    logic [AW:0] len_q;
    logic [AW:0] idx_q;
    logic        hs;
    logic [AW:0] hdr_len;
    logic        last_word;
`ifdef ICCM_BOOT_CSUM_EN
    logic [DW-1:0] sum_q;
`endif

    assign hs        = bus.s_valid_i & bus.s_ready_o;
    assign hdr_len   = bus.s_data_i[AW:0];
    assign last_word = (idx_q == len_q - 1'b1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            idx_q            <= '0;
`ifdef ICCM_BOOT_CSUM_EN
            sum_q            <= '0;
`endif
            bus.s_ready_o    <= 1'b0;
            bus.iccm_we_o    <= 1'b0;
            bus.iccm_wdata_o <= '0;
            bus.iccm_wmask_o <= '0;
            bus.iccm_waddr_o <= '0;
            finish_o         <= 1'b0;
            err_o            <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            // Write strobe and mask are pulses; address and data hold.
            bus.iccm_we_o    <= 1'b0;
            bus.iccm_wmask_o <= '0;

            if (abort_i) begin
                state_q       <= ST_IDLE;
                bus.s_ready_o <= 1'b0;
                finish_o      <= 1'b0;
                err_o         <= 1'b0;
                busy_o        <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            state_q       <= ST_HDR;
                            bus.s_ready_o <= 1'b1;
                            busy_o        <= 1'b1;
                        end
                    end

                    ST_HDR: begin
                        if (hs) begin
                            if (hdr_len == '0 || hdr_len > LEN_MAX) begin
                                state_q       <= ST_ERR;
                                bus.s_ready_o <= 1'b0;
                                busy_o        <= 1'b0;
                                err_o         <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                                len_q   <= hdr_len;
                                idx_q   <= '0;
`ifdef ICCM_BOOT_CSUM_EN
                                sum_q   <= '0;
`endif
                            end
                        end
                    end

                    ST_LOAD: begin
                        if (hs) begin
                            bus.iccm_we_o    <= 1'b1;
                            bus.iccm_wmask_o <= '1;
                            bus.iccm_wdata_o <= bus.s_data_i;
                            bus.iccm_waddr_o <= AW'(BASE_ADDR) + idx_q[AW-1:0];
                            idx_q            <= idx_q + 1'b1;
`ifdef ICCM_BOOT_CSUM_EN
                            sum_q            <= sum_q + bus.s_data_i;
                            if (last_word) begin
                                state_q <= ST_CSUM;
                            end
`else
                            if (last_word) begin
                                state_q       <= ST_DONE;
                                bus.s_ready_o <= 1'b0;
                                busy_o        <= 1'b0;
                            end
`endif
                        end
                    end

                    ST_CSUM: begin
`ifdef ICCM_BOOT_CSUM_EN
                        if (hs) begin
                            bus.s_ready_o <= 1'b0;
                            busy_o        <= 1'b0;
                            if (bus.s_data_i == sum_q) begin
                                state_q  <= ST_DONE;
                                finish_o <= 1'b1;
                            end else begin
                                state_q <= ST_ERR;
                                err_o   <= 1'b1;
                            end
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end

                    // finish_o rises one cycle after the last write pulse and stays up.
                    ST_DONE: begin
                        finish_o <= 1'b1;
                    end

                    ST_ERR: begin
                        if (start_i) begin
                            state_q       <= ST_HDR;
                            err_o         <= 1'b0;
                            bus.s_ready_o <= 1'b1;
                            busy_o        <= 1'b1;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
